framebuffer_stream_reader: RTL and testbench

//  Read-side master for the dual-clock framebuffer BRAM: on start, walks read addresses 0..DEPTH-1
//  on the BRAM read port (1-cycle read latency) and presents each word as a valid/ready stream.

---
 rtl/fb_reader_pkg.sv | 13 +
 rtl/skid_fifo2.sv | 67 ++++++
 rtl/framebuffer_stream_reader.sv | 110 +++++++++++
 tb/tb_framebuffer_stream_reader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_reader_pkg.sv
// Shared types and constants for the framebuffer stream reader.
package fb_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with the head entry held in a register that drives the output directly.
module skid_fifo2
  import fb_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [WIDTH-1:0]      head_q, head_d;
  logic [WIDTH-1:0]      tail_q, tail_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;

  // Next entry contents; pop is only ever requested with a non-empty FIFO.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (count_q == '0) head_d = din_i;
        else               tail_d = din_i;
        count_d = count_q + FIFO_CNT_W'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - FIFO_CNT_W'(1);
      end
      2'b11: begin
        if (count_q == FIFO_CNT_W'(1)) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout_o  = head_q;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));

endmodule

// File: rtl/framebuffer_stream_reader.sv
// Walks the framebuffer BRAM once per start and streams the words out with valid/ready.
module framebuffer_stream_reader
  import fb_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  inflight_q, inflight_last_q;
  logic                  issue, credit_ok, pop, issue_last;
  logic [DATA_W:0]       fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;

  assign pop        = m_valid && m_ready;
  assign issue_last = issue && (addr_q == LAST_ADDR);

  // Credit: occupancy + in-flight read - this cycle's pop must stay below the FIFO depth.
  // Counting the pop keeps one read per cycle under continuous m_ready, at the cost of a
  // combinational path from m_ready to ram_en.
  always_comb begin
    credit_ok = 1'b0;
    if (inflight_q) credit_ok = fifo_empty || ((fifo_count == FIFO_CNT_W'(1)) && pop);
    else            credit_ok = !fifo_full || pop;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: fetch until the last address is issued, drain until the last word leaves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)          state_d = FETCH;
      FETCH:   if (issue_last)     state_d = DRAIN;
      DRAIN:   if (pop && m_last)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // FSM outputs: busy outside IDLE, reads only in FETCH with credit.
  always_comb begin
    busy  = 1'b0;
    issue = 1'b0;
    if (state_q != IDLE)                 busy  = 1'b1;
    if (state_q == FETCH && credit_ok)   issue = 1'b1;
  end

  // Address advances per issued read and returns to 0 after the last one.
  always_comb begin
    addr_d = addr_q;
    if (issue) addr_d = issue_last ? '0 : addr_q + ADDR_W'(1);
  end

  // Address counter and in-flight tracking for the 1-cycle BRAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
    end
  end

  skid_fifo2 #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .din_i   ({inflight_last_q, ram_dout}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign ram_en     = issue;
  assign ram_addr   = addr_q;
  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_dout[DATA_W-1:0];
  assign m_last     = fifo_dout[DATA_W];
  assign frame_done = pop && m_last;

endmodule

// File: tb/tb_framebuffer_stream_reader.sv
// Bench for framebuffer_stream_reader: DEPTH=8 directed scenarios plus DEPTH=2 random frames.
module tb_framebuffer_stream_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic        start8 = 1'b0, m_ready8 = 1'b0;
  logic        busy8, frame_done8, ram_en8, m_valid8, m_last8;
  logic [3:0]  ram_addr8;
  logic [15:0] ram_dout8 = '0, m_data8;

  // DEPTH=2 instance
  logic        start2 = 1'b0, m_ready2 = 1'b0;
  logic        busy2, frame_done2, ram_en2, m_valid2, m_last2;
  logic [0:0]  ram_addr2;
  logic [15:0] ram_dout2 = '0, m_data2;

  framebuffer_stream_reader #(.ADDR_W(4), .DATA_W(16), .DEPTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .busy(busy8), .frame_done(frame_done8),
    .ram_en(ram_en8), .ram_addr(ram_addr8), .ram_dout(ram_dout8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .m_last(m_last8));

  framebuffer_stream_reader #(.ADDR_W(1), .DATA_W(16), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .frame_done(frame_done2),
    .ram_en(ram_en2), .ram_addr(ram_addr2), .ram_dout(ram_dout2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2));

  // BRAM models preloaded with 0x1000+address, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en8) ram_dout8 <= 16'h1000 + 16'(ram_addr8);
    if (ram_en2) ram_dout2 <= 16'h1000 + 16'(ram_addr2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      2:       return c > 20;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic check_reset8(input string tag);
    chk({tag, "_busy"},  32'(busy8), 32'(0));
    chk({tag, "_done"},  32'(frame_done8), 32'(0));
    chk({tag, "_ram_en"}, 32'(ram_en8), 32'(0));
    chk({tag, "_addr"},  32'(ram_addr8), 32'(0));
    chk({tag, "_valid"}, 32'(m_valid8), 32'(0));
    chk({tag, "_last"},  32'(m_last8), 32'(0));
    chk({tag, "_data"},  32'(m_data8), 32'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start8 = 1'b0; start2 = 1'b0; m_ready8 = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy8), 32'(0));
      chk("idle_ram_en", 32'(ram_en8), 32'(0));
      chk("idle_valid", 32'(m_valid8), 32'(0));
    end
  endtask

  // One DEPTH=8 frame: start in cycle 0, scoreboard on every handshake.
  task automatic run8(input int mode, input bit timing, input bit extra_starts);
    int idx = 0, issued = 0, outstanding = 0;
    bit done = 1'b0, prev_stall = 1'b0, hs;
    logic [15:0] prev_data = '0;
    @(posedge clk); #1;
    start8 = 1'b1; m_ready8 = ready_for(mode, 0);
    @(negedge clk);
    chk("c0_busy", 32'(busy8), 32'(0));
    chk("c0_ram_en", 32'(ram_en8), 32'(0));
    for (int c = 1; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      start8   = extra_starts && (c == 5 || c == 10);
      m_ready8 = ready_for(mode, c);
      @(negedge clk);
      hs = m_valid8 && m_ready8;
      chk("busy", 32'(busy8), 32'(1));
      if (timing) begin
        chk("t_ram_en", 32'(ram_en8), 32'(c >= 1 && c <= 8));
        chk("t_valid", 32'(m_valid8), 32'(c >= 3 && c <= 10));
        chk("t_done", 32'(frame_done8), 32'(c == 10));
      end
      if (ram_en8) begin
        chk("addr", 32'(ram_addr8), 32'(issued));
        chk("credit", 32'((outstanding - int'(hs)) <= 1), 32'(1));
        issued++;
        outstanding++;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid8), 32'(1));
        chk("stall_data", 32'(m_data8), 32'(prev_data));
      end
      if (hs) begin
        chk("data", 32'(m_data8), 32'(16'h1000 + 16'(idx)));
        chk("last", 32'(m_last8), 32'(idx == 7));
        chk("done", 32'(frame_done8), 32'(idx == 7));
        idx++;
        outstanding--;
      end else begin
        chk("done_no_hs", 32'(frame_done8), 32'(0));
      end
      if (mode == 2 && c == 20) begin
        chk("hold_reads", 32'(issued), 32'(2));
        chk("hold_valid", 32'(m_valid8), 32'(1));
        chk("hold_data", 32'(m_data8), 32'(16'h1000));
      end
      prev_stall = m_valid8 && !m_ready8;
      prev_data  = m_data8;
      if (frame_done8) done = 1'b1;
    end
    chk("frame_completed", 32'(done), 32'(1));
    chk("frame_words", 32'(idx), 32'(8));
    chk("frame_reads", 32'(issued), 32'(8));
  endtask

  // Reset in cycle 6 of an active frame.
  task automatic reset_mid8();
    @(posedge clk); #1;
    start8 = 1'b1; m_ready8 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      reset  = (c == 6);
      @(negedge clk);
      if (c == 5) chk("pre_reset_valid", 32'(m_valid8), 32'(1));
    end
    check_reset8("midreset");
  endtask

  // DEPTH=2 frames with random backpressure.
  task automatic run2_random(input int frames);
    for (int f = 0; f < frames; f++) begin
      int idx = 0, dones = 0;
      bit done = 1'b0, prev_stall = 1'b0, hs;
      logic [15:0] prev_data = '0;
      @(posedge clk); #1;
      start2 = 1'b1; m_ready2 = 1'($urandom % 2);
      @(negedge clk);
      chk("d2_c0_busy", 32'(busy2), 32'(0));
      for (int c = 1; c < 100 && !done; c++) begin
        @(posedge clk); #1;
        start2 = 1'($urandom % 2);
        m_ready2 = 1'($urandom % 2);
        @(negedge clk);
        hs = m_valid2 && m_ready2;
        if (prev_stall) chk("d2_stall_data", 32'(m_data2), 32'(prev_data));
        if (hs) begin
          chk("d2_data", 32'(m_data2), 32'(16'h1000 + 16'(idx)));
          chk("d2_last", 32'(m_last2), 32'(idx == 1));
          idx++;
        end
        if (frame_done2) begin
          dones++;
          done = 1'b1;
        end
        prev_stall = m_valid2 && !m_ready2;
        prev_data  = m_data2;
      end
      chk("d2_words", 32'(idx), 32'(2));
      chk("d2_dones", 32'(dones), 32'(1));
      @(posedge clk); #1;
      start2 = 1'b0;
      @(negedge clk);
      chk("d2_busy_after", 32'(busy2), 32'(0));
    end
  endtask

  initial begin
    void'($urandom(32'h00C0FFEE));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset8("reset");
    chk("reset_d2_valid", 32'(m_valid2), 32'(0));
    chk("reset_d2_busy", 32'(busy2), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    run8(0, 1'b1, 1'b0);   // full rate, exact cycle timing
    run8(0, 1'b1, 1'b1);   // extra starts in cycles 5 and 10 ignored
    run8(0, 1'b1, 1'b0);   // started in the cycle after frame_done
    idle(2);
    run8(1, 1'b0, 1'b0);   // ready pattern 1,0,0,1
    idle(1);
    run8(2, 1'b0, 1'b0);   // ready low for 20 cycles
    idle(1);
    reset_mid8();
    idle(1);
    run8(0, 1'b1, 1'b0);   // clean frame after mid-frame reset
    idle(3);
    run2_random(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
